demultiplekser: RTL and testbench
=================================

Name: demultiplekser

Overview:
- 1-to-9 demultiplexer with registered outputs: the distribution counterpart of the 9:1 16-bit multiplexer.
- A single 16-bit input word is steered into one of nine holding registers, oQ0..oQ8.
- The destination is either given explicitly by iSEL (manual mode) or taken from an internal round-robin pointer (auto mode).
- Each accepted write produces a one-cycle strobe on the destination channel, so downstream consumers know which register just changed.

Parameters:
- WIDTH, 16, data width of iD and of each of oQ0..oQ8.

Ports:
- iCLK  input  1  system clock; all state updates on its rising edge.
- iRST  input  1  synchronous, active-high reset.
- iD  input  WIDTH  data word to distribute.
- iSEL  input  4  manual destination index; valid values 0..8.
- iWE  input  1  write enable; one write per cycle when high.
- iAUTO  input  1  1 = destination is the internal pointer; 0 = destination is iSEL.
- iCLR  input  1  synchronous clear of the round-robin pointer; stored data is not affected.
- oQ0..oQ8  output  WIDTH each  holding registers for channels 0..8.
- oSTB  output  9  one-hot write strobe; bit k is high for one cycle after channel k is written.
- oPTR  output  4  current round-robin pointer, range 0..8.
- oERR  output  1  sticky error flag: a manual write addressed an out-of-range index.

Behaviour:
- Reset: while iRST=1 at a rising edge, all of the following are set to 0: oQ0..oQ8, oSTB, oPTR, oERR. iRST overrides every other input in that cycle. A reset arriving mid-sequence discards the pointer position.
- Effective pointer for a cycle:
  - ep = 0 if iCLR=1.
  - Otherwise ep = oPTR.
- Target for a cycle:
  - t = ep if iAUTO=1.
  - t = iSEL if iAUTO=0.
- Accepted write: iWE=1 and t<=8. At the next edge:
  - oQt <= iD; all other oQk hold.
  - oSTB <= one-hot(t).
- Latency: iD appears on oQt, and oSTB[t] rises, one clock after the write edge. oQt holds its value until that channel is written again.
- oSTB is 0 in every cycle that follows a cycle with no accepted write. oSTB is never multi-hot.
- Out-of-range manual write: iAUTO=0, iWE=1, iSEL in 9..15. At the next edge:
  - No oQ changes.
  - oSTB <= 0.
  - oERR <= 1.
- oERR clears only on iRST. iSEL is ignored when iAUTO=1, so auto mode never raises oERR.
- Pointer update:
  - Auto mode with an accepted write: oPTR <= (ep==8) ? 0 : ep+1, wrapping 8 -> 0.
  - iCLR=1 without an auto write: oPTR <= 0.
  - All other cases: oPTR holds. Manual writes never move the pointer.
- Simultaneous iCLR=1, iAUTO=1, iWE=1: the write goes to channel 0 and oPTR <= 1.
- Switching iAUTO between cycles is legal. The pointer resumes from its held value.
- No back-pressure: a write is accepted in every cycle iWE=1 and the target is valid.
- Implementation: a 4-bit pointer register, 9 WIDTH-bit data registers, a 9-bit strobe register and 1 error flop. Decode is combinational from t.

Test Plan:
- Reset: drive iRST=1 for 2 cycles with iWE=1, iD=16'hFFFF -> all oQk=0, oSTB=0, oPTR=0, oERR=0 after release.
- Manual write: iAUTO=0, iSEL=5, iD=16'hA5A5, iWE=1 for 1 cycle -> next cycle oQ5=16'hA5A5, oSTB=9'b000100000; following cycle oSTB=0, oQ5 holds, oPTR=0.
- Auto sweep: iAUTO=1, iWE=1 for 10 consecutive cycles with iD=1..10 -> oQ0..oQ8=1..9, then oQ0=10; oPTR steps 1,2,..,8,0,1; oSTB walks one-hot bit0..bit8, then bit0.
- Out-of-range write: iAUTO=0, iSEL=12, iD=16'h1234, iWE=1 -> no oQ changes, oSTB=0, oERR=1. oERR stays 1 across later valid writes and clears only after iRST.
- Clear collision: with oPTR=6, apply iCLR=1, iAUTO=1, iWE=1, iD=16'h00C3 -> oQ0=16'h00C3, oSTB bit0 set, oPTR=1. iCLR alone with iWE=0 -> oPTR=0, all data unchanged.
- Reset mid-operation: after 4 auto writes (oPTR=4), assert iRST for 1 cycle together with iWE=1 -> all outputs 0. The next auto write lands in oQ0.

Source files
------------

// File: rtl/demultiplekser_if.sv
// Bus bundle for the 1-to-9 demultiplexer: write-side controls in, holding registers and status out.
interface demultiplekser_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] iD;
    logic [3:0]       iSEL;
    logic             iWE;
    logic             iAUTO;
    logic             iCLR;
    logic [WIDTH-1:0] oQ0, oQ1, oQ2, oQ3, oQ4, oQ5, oQ6, oQ7, oQ8;
    logic [8:0]       oSTB;
    logic [3:0]       oPTR;
    logic             oERR;

    modport master (
        output iD, iSEL, iWE, iAUTO, iCLR,
        input  oQ0, oQ1, oQ2, oQ3, oQ4, oQ5, oQ6, oQ7, oQ8, oSTB, oPTR, oERR
    );

    modport slave (
        input  iD, iSEL, iWE, iAUTO, iCLR,
        output oQ0, oQ1, oQ2, oQ3, oQ4, oQ5, oQ6, oQ7, oQ8, oSTB, oPTR, oERR
    );
endinterface

// File: rtl/demultiplekser.sv
// 1-to-9 demultiplexer with registered outputs; destination from iSEL (manual) or a
// round-robin pointer (auto), one-hot write strobe and a sticky out-of-range error flag.
module demultiplekser #(
    parameter int WIDTH = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    demultiplekser_if.slave bus
);
    logic [WIDTH-1:0] data_q [9];
    logic [WIDTH-1:0] data_d [9];
    logic [8:0]       stb_q, stb_d;
    logic [3:0]       ptr_q, ptr_d;
    logic             err_q, err_d;

    logic [3:0]       ep;
    logic [3:0]       tgt;
    logic             accept;

    always_comb begin
        // iCLR zeroes the pointer seen this cycle, so a colliding auto write lands in channel 0
        ep     = bus.iCLR ? 4'd0 : ptr_q;
        tgt    = bus.iAUTO ? ep : bus.iSEL;
        accept = bus.iWE && (tgt <= 4'd8);

        for (int k = 0; k < 9; k++) begin
            data_d[k] = data_q[k];
            if (accept && (tgt == 4'(k))) begin
                data_d[k] = bus.iD;
            end
        end

        stb_d = accept ? (9'd1 << tgt) : 9'd0;

        ptr_d = ptr_q;
        if (bus.iAUTO && accept) begin
            ptr_d = (ep == 4'd8) ? 4'd0 : ep + 4'd1;
        end else if (bus.iCLR) begin
            ptr_d = 4'd0;
        end

        err_d = err_q | (!bus.iAUTO && bus.iWE && (bus.iSEL > 4'd8));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < 9; k++) begin
                data_q[k] <= '0;
            end
            stb_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                data_q[k] <= data_d[k];
            end
            stb_q <= stb_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign bus.oQ0  = data_q[0];
    assign bus.oQ1  = data_q[1];
    assign bus.oQ2  = data_q[2];
    assign bus.oQ3  = data_q[3];
    assign bus.oQ4  = data_q[4];
    assign bus.oQ5  = data_q[5];
    assign bus.oQ6  = data_q[6];
    assign bus.oQ7  = data_q[7];
    assign bus.oQ8  = data_q[8];
    assign bus.oSTB = stb_q;
    assign bus.oPTR = ptr_q;
    assign bus.oERR = err_q;
endmodule

// File: tb/tb_demultiplekser.sv
// Self-checking bench for demultiplekser: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_demultiplekser;
    logic iCLK;
    logic iRST;

    demultiplekser_if #(.WIDTH(16)) bus ();

    demultiplekser #(.WIDTH(16)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] q_arr [9];
    assign q_arr[0] = bus.oQ0;
    assign q_arr[1] = bus.oQ1;
    assign q_arr[2] = bus.oQ2;
    assign q_arr[3] = bus.oQ3;
    assign q_arr[4] = bus.oQ4;
    assign q_arr[5] = bus.oQ5;
    assign q_arr[6] = bus.oQ6;
    assign q_arr[7] = bus.oQ7;
    assign q_arr[8] = bus.oQ8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, destination computed directly, pointer advanced modulo 9
    int mq [9];
    int mstb;
    int mptr;
    int merr;
    bit mvalid = 1'b0;
    int dest;

    always @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < 9; k++) mq[k] = 0;
            mstb = 0; mptr = 0; merr = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (bus.iAUTO) dest = bus.iCLR ? 0 : mptr;
            else           dest = int'(bus.iSEL);
            if (bus.iWE && dest < 9) begin
                mq[dest] = int'(bus.iD);
                mstb = 1 << dest;
                if (bus.iAUTO)     mptr = (dest + 1) % 9;
                else if (bus.iCLR) mptr = 0;
            end else begin
                mstb = 0;
                if (bus.iCLR) mptr = 0;
                if (bus.iWE && !bus.iAUTO) merr = 1;
            end
        end
    end

    always @(negedge iCLK) begin
        if (mvalid) begin
            for (int k = 0; k < 9; k++) chk($sformatf("model_oQ%0d", k), 32'(q_arr[k]), 32'(mq[k]));
            chk("model_oSTB", 32'(bus.oSTB), 32'(mstb));
            chk("model_oPTR", 32'(bus.oPTR), 32'(mptr));
            chk("model_oERR", 32'(bus.oERR), 32'(merr));
        end
    end

    task automatic cyc(input logic rst, input logic we, input logic auto_m, input logic clr,
                       input logic [3:0] sel, input logic [15:0] d);
        iRST      = rst;
        bus.iWE   = we;
        bus.iAUTO = auto_m;
        bus.iCLR  = clr;
        bus.iSEL  = sel;
        bus.iD    = d;
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        iRST = 1'b1; bus.iWE = 1'b1; bus.iAUTO = 1'b0; bus.iCLR = 1'b0;
        bus.iSEL = 4'd0; bus.iD = 16'hFFFF;

        // Reset with a write pending
        cyc(1, 1, 0, 0, 4'd0, 16'hFFFF);
        cyc(1, 1, 0, 0, 4'd0, 16'hFFFF);
        chk("rst_oPTR", 32'(bus.oPTR), 32'd0);
        chk("rst_oSTB", 32'(bus.oSTB), 32'd0);
        chk("rst_oERR", 32'(bus.oERR), 32'd0);
        chk("rst_oQ0",  32'(bus.oQ0),  32'd0);

        // Manual write to channel 5
        cyc(0, 1, 0, 0, 4'd5, 16'hA5A5);
        chk("man_oQ5",  32'(bus.oQ5),  32'hA5A5);
        chk("man_oSTB", 32'(bus.oSTB), 32'b000100000);
        cyc(0, 0, 0, 0, 4'd5, 16'h0000);
        chk("man_idle_oSTB", 32'(bus.oSTB), 32'd0);
        chk("man_idle_oQ5",  32'(bus.oQ5),  32'hA5A5);
        chk("man_idle_oPTR", 32'(bus.oPTR), 32'd0);

        // Auto sweep of ten writes
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 1, 0, 4'd15, 16'(i));
            chk("sweep_oPTR", 32'(bus.oPTR), 32'(i % 9));
            chk("sweep_oSTB", 32'(bus.oSTB), 32'(1 << ((i - 1) % 9)));
        end
        chk("sweep_oQ0", 32'(bus.oQ0), 32'd10);
        chk("sweep_oQ4", 32'(bus.oQ4), 32'd5);
        chk("sweep_oQ8", 32'(bus.oQ8), 32'd9);

        // Out-of-range manual write
        cyc(0, 1, 0, 0, 4'd12, 16'h1234);
        chk("oor_oSTB", 32'(bus.oSTB), 32'd0);
        chk("oor_oERR", 32'(bus.oERR), 32'd1);
        chk("oor_oQ5",  32'(bus.oQ5),  32'd6);
        cyc(0, 1, 0, 0, 4'd2, 16'h5555);
        chk("oor_sticky_oERR", 32'(bus.oERR), 32'd1);
        chk("oor_after_oQ2",   32'(bus.oQ2),  32'h5555);

        // Drive pointer from 1 to 6, then collide clear with an auto write
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 4'd0, 16'(20 + i));
        chk("pre_clr_oPTR", 32'(bus.oPTR), 32'd6);
        cyc(0, 1, 1, 1, 4'd0, 16'h00C3);
        chk("clr_oQ0",  32'(bus.oQ0),  32'h00C3);
        chk("clr_oSTB", 32'(bus.oSTB), 32'd1);
        chk("clr_oPTR", 32'(bus.oPTR), 32'd1);
        cyc(0, 0, 1, 1, 4'd0, 16'hDEAD);
        chk("clr_only_oPTR", 32'(bus.oPTR), 32'd0);
        chk("clr_only_oQ0",  32'(bus.oQ0),  32'h00C3);
        chk("clr_only_oSTB", 32'(bus.oSTB), 32'd0);

        // Reset clears the sticky error, then reset mid-sweep
        cyc(1, 0, 0, 0, 4'd0, 16'h0000);
        chk("rst2_oERR", 32'(bus.oERR), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd0, 16'(40 + i));
        chk("mid_oPTR", 32'(bus.oPTR), 32'd4);
        cyc(1, 1, 1, 0, 4'd0, 16'hBEEF);
        chk("mid_rst_oPTR", 32'(bus.oPTR), 32'd0);
        chk("mid_rst_oQ3",  32'(bus.oQ3),  32'd0);
        chk("mid_rst_oSTB", 32'(bus.oSTB), 32'd0);
        cyc(0, 1, 1, 0, 4'd0, 16'h0077);
        chk("mid_next_oQ0",  32'(bus.oQ0),  32'h0077);
        chk("mid_next_oPTR", 32'(bus.oPTR), 32'd1);

        // Randomized traffic, checked each cycle by the model
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 7) == 0),
                4'($urandom_range(0, 15)),
                16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
